// File: rtl/adder_stage_pkg.sv
// +------------------------------------------------------------------+
// | adder_stage_pkg                                                  |
// | Shared widths, defaults and beat layout for the adder stream.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package adder_stage_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int METER_BEATS_DEF = 1024;
   localparam int COUNT_W         = 32;

   // Beat layout at the default width; the top rebuilds it for its own DATA_W.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  last;
      logic [DATA_W_DEF-1:0] addend;
      logic                  act;
   } beat_t;

endpackage : adder_stage_pkg

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// +------------------------------------------------------------------+
// | axis_skid_buffer                                                 |
// | One-entry skid buffer with registered ready, zero-latency bypass.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s_data_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i
);

   logic             full_q;
   logic             full_d;
   logic             ready_q;
   logic [WIDTH-1:0] buf_q;
   logic [WIDTH-1:0] buf_d;
   logic             accept;

   assign accept = s_valid_i & ready_q;

   always_comb begin
      full_d = full_q;
      buf_d  = buf_q;
      if (full_q) begin
         if (m_ready_i) begin
            full_d = 1'b0;
         end
      end else if (accept && !m_ready_i) begin
         full_d = 1'b1;
         buf_d  = s_data_i;
      end
   end

   // ready_q is cleared in reset so the first accept follows the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         ready_q <= 1'b0;
         buf_q   <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ~full_d;
         buf_q   <= buf_d;
      end
   end

   assign s_ready_o = ready_q;
   assign m_valid_o = full_q | accept;
   assign m_data_o  = full_q ? buf_q : s_data_i;

endmodule : axis_skid_buffer

`default_nettype wire

// File: rtl/adder_stream_stage.sv
// +------------------------------------------------------------------+
// | adder_stream_stage                                               |
// | Metered AXI4-Stream adder: skid + capture + compute stages.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module adder_stream_stage
   import adder_stage_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int METER_BEATS = METER_BEATS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               activated,
   input  logic [DATA_W-1:0]  addend,
   input  logic [DATA_W-1:0]  s_axis_tdata,
   input  logic               s_axis_tvalid,
   input  logic               s_axis_tlast,
   output logic               s_axis_tready,
   output logic [DATA_W-1:0]  m_axis_tdata,
   output logic               m_axis_tvalid,
   output logic               m_axis_tlast,
   output logic               m_axis_tuser,
   input  logic               m_axis_tready,
   output logic               metering_event,
   output logic [COUNT_W-1:0] beat_count
);

   localparam int MCNT_W = (METER_BEATS > 1) ? $clog2(METER_BEATS) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [DATA_W-1:0] addend;
      logic              act;
   } stage_beat_t;

   stage_beat_t in_beat;
   stage_beat_t skid_beat;
   logic        skid_valid;
   logic        s1_ready;
   logic        s2_ready;

   stage_beat_t s1_q, s1_d;
   logic        s1_valid_q, s1_valid_d;

   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic              s2_last_q, s2_last_d;
   logic              s2_carry_q, s2_carry_d;
   logic              s2_act_q, s2_act_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W:0]   sum;

   logic [MCNT_W-1:0]  mcnt_q, mcnt_d;
   logic               meter_q, meter_d;
   logic [COUNT_W-1:0] bcnt_q, bcnt_d;
   logic               hs_act;

   // Operands travel with the beat so a flag change only affects later beats
   assign in_beat = {s_axis_tdata, s_axis_tlast, addend, activated};

   axis_skid_buffer #(
      .WIDTH ($bits(stage_beat_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data_i  (in_beat),
      .s_valid_i (s_axis_tvalid),
      .s_ready_o (s_axis_tready),
      .m_data_o  (skid_beat),
      .m_valid_o (skid_valid),
      .m_ready_i (s1_ready)
   );

   assign s2_ready = ~s2_valid_q | m_axis_tready;
   assign s1_ready = ~s1_valid_q | s2_ready;
   assign sum      = {1'b0, s1_q.data} + {1'b0, s1_q.addend};

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (s1_ready) begin
         s1_valid_d = skid_valid;
         if (skid_valid) begin
            s1_d = skid_beat;
         end
      end
   end

   always_comb begin
      s2_data_d  = s2_data_q;
      s2_last_d  = s2_last_q;
      s2_carry_d = s2_carry_q;
      s2_act_d   = s2_act_q;
      s2_valid_d = s2_valid_q;
      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_last_d  = s1_q.last;
            s2_act_d   = s1_q.act;
            s2_data_d  = s1_q.act ? sum[DATA_W-1:0] : s1_q.data;
            s2_carry_d = s1_q.act & sum[DATA_W];
         end
      end
   end

   assign hs_act = s2_valid_q & m_axis_tready & s2_act_q;

   always_comb begin
      mcnt_d  = mcnt_q;
      meter_d = 1'b0;
      bcnt_d  = bcnt_q;
      if (hs_act) begin
         if (mcnt_q == MCNT_W'(METER_BEATS - 1)) begin
            mcnt_d  = '0;
            meter_d = 1'b1;
         end else begin
            mcnt_d = mcnt_q + 1'b1;
         end
         if (bcnt_q != '1) begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
         s2_carry_q <= 1'b0;
         s2_act_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         mcnt_q     <= '0;
         meter_q    <= 1'b0;
         bcnt_q     <= '0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
         s2_carry_q <= s2_carry_d;
         s2_act_q   <= s2_act_d;
         s2_valid_q <= s2_valid_d;
         mcnt_q     <= mcnt_d;
         meter_q    <= meter_d;
         bcnt_q     <= bcnt_d;
      end
   end

   assign m_axis_tdata   = s2_data_q;
   assign m_axis_tvalid  = s2_valid_q;
   assign m_axis_tlast   = s2_last_q;
   assign m_axis_tuser   = s2_carry_q;
   assign metering_event = meter_q;
   assign beat_count     = bcnt_q;

endmodule : adder_stream_stage

`default_nettype wire

// File: tb/tb_adder_stream_stage.sv
// +------------------------------------------------------------------+
// | tb_adder_stream_stage                                            |
// | Self-checking bench with a queue-based reference model.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_adder_stream_stage;

   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          activated = 1'b0;
   logic [DW-1:0] addend = '0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tuser;
   logic          m_tready = 1'b1;
   logic          metering_event;
   logic [31:0]   beat_count;

   adder_stream_stage #(.DATA_W(DW), .METER_BEATS(MB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .activated      (activated),
      .addend         (addend),
      .s_axis_tdata   (s_tdata),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tlast   (s_tlast),
      .s_axis_tready  (s_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tlast   (m_tlast),
      .m_axis_tuser   (m_tuser),
      .m_axis_tready  (m_tready),
      .metering_event (metering_event),
      .beat_count     (beat_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          carry;
      logic          act;
   } exp_t;

   exp_t          exp_q[$];
   int            act_total = 0;
   int            in_cnt = 0;
   int            pulses = 0;
   logic          meter_pend = 1'b0;
   logic          hold_prev = 1'b0;
   logic [DW+1:0] prev_out = '0;

   // Reference model: expected results are computed at the input handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         act_total  = 0;
         meter_pend = 1'b0;
         hold_prev  = 1'b0;
      end else begin
         exp_t     e;
         logic [DW:0] full;
         chk("meter_event", metering_event, meter_pend);
         chk("beat_count", beat_count, act_total);
         if (metering_event) pulses++;
         if (hold_prev) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_data", {m_tdata, m_tlast, m_tuser}, prev_out);
         end
         meter_pend = 1'b0;
         if (s_tvalid && s_tready) begin
            full    = {1'b0, s_tdata} + {1'b0, addend};
            e.data  = activated ? full[DW-1:0] : s_tdata;
            e.carry = activated ? full[DW] : 1'b0;
            e.last  = s_tlast;
            e.act   = activated;
            exp_q.push_back(e);
            in_cnt++;
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", {m_tdata, m_tlast, m_tuser}, {e.data, e.last, e.carry});
               if (e.act) begin
                  act_total++;
                  if (act_total % MB == 0) meter_pend = 1'b1;
               end
            end
         end
         hold_prev = m_tvalid && !m_tready;
         prev_out  = {m_tdata, m_tlast, m_tuser};
      end
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      int n = 0;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) chk("send_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic rand_done = 1'b0;

   initial begin
      int p0;
      int tgt;
      int k;

      // Reset state
      @(negedge clk);
      chk("rst_tready", s_tready, 1'b0);
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_out", {m_tdata, m_tlast, m_tuser, metering_event}, '0);
      chk("rst_bcnt", beat_count, '0);
      tick(2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("tready_post_rel", s_tready, 1'b0);
      @(negedge clk);
      chk("tready_rise", s_tready, 1'b1);
      @(posedge clk); #1;

      // Single activated beat and its latency
      activated = 1'b1; addend = 32'd5; m_tready = 1'b1;
      send_beat(32'h10, 1'b1);
      s_tvalid = 1'b0;
      @(negedge clk);
      chk("lat_not_yet", m_tvalid, 1'b0);
      @(negedge clk);
      chk("lat_valid", m_tvalid, 1'b1);
      chk("t1_out", {m_tdata, m_tlast, m_tuser}, {32'h15, 1'b1, 1'b0});
      @(negedge clk);
      chk("t1_bcnt", beat_count, 32'd1);
      @(posedge clk); #1;

      // Wrap with carry
      addend = 32'd1;
      send_beat(32'hFFFF_FFFF, 1'b0);
      s_tvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t2_out", {m_tdata, m_tuser}, {32'h0, 1'b1});
      @(posedge clk); #1;

      // Bypass beat
      activated = 1'b0; addend = 32'd5;
      p0 = pulses;
      send_beat(32'h1234, 1'b1);
      s_tvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_out", {m_tdata, m_tuser}, {32'h1234, 1'b0});
      tick(2);
      chk("t3_bcnt", beat_count, 32'd2);
      chk("t3_pulses", pulses - p0, 0);

      // Burst with mid-burst stall
      activated = 1'b1; addend = 32'h100; m_tready = 1'b0;
      tgt = in_cnt + 3;
      fork
         begin
            for (int i = 0; i < 8; i++) send_beat(i, i == 7);
            s_tvalid = 1'b0;
         end
         begin
            k = 0;
            do begin
               @(negedge clk); #1; k++;
            end while (in_cnt < tgt && k < 50);
            chk("t4_fill_to", in_cnt >= tgt, 1'b1);
            @(negedge clk);
            chk("t4_tready_low", s_tready, 1'b0);
            tick(5);
            m_tready = 1'b1;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("t4_no_gap", m_tvalid, 1'b1);
            end
         end
      join
      tick(4);

      // Reset with beats in flight
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(32'hA0 + i, 1'b0);
      s_tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", m_tvalid, 1'b0);
      chk("t6_async_bcnt", beat_count, '0);
      tick(2);
      rst_n = 1'b1;
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_stale", m_tvalid, 1'b0);
      end
      chk("t6_bcnt", beat_count, '0);
      @(posedge clk); #1;

      // Metering over mixed activated and bypass beats
      p0 = pulses;
      begin
         logic [10:0] pat;
         pat = 11'b11110111011;
         for (int i = 0; i < 11; i++) begin
            activated = pat[i];
            addend    = $urandom;
            send_beat($urandom, i == 10);
         end
      end
      s_tvalid = 1'b0;
      tick(4);
      chk("t5_pulses", pulses - p0, 2);
      chk("t5_bcnt", beat_count, 32'd9);

      // Randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 4) == 0) begin
                  s_tvalid = 1'b0;
                  tick(1);
               end else begin
                  activated = ($urandom_range(0, 3) != 0);
                  addend    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                  send_beat($urandom, $urandom_range(0, 1) == 1);
               end
            end
            s_tvalid  = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               m_tready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      m_tready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(negedge clk); #1; k++;
      end
      chk("drain", exp_q.size(), 0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_adder_stream_stage

`default_nettype wire
